// File: rtl/pc_update.sv
// Y86-64 program counter and architectural status tracker (AOK/HLT/ADR/INS).
// Define PC_UPDATE_PERF_EN to add the cycle and retired-instruction counters.
module pc_update #(
  parameter logic [63:0] RESET_PC = 64'h0
`ifdef PC_UPDATE_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [3:0]  icode_i,
  input  logic        cnd_i,
  input  logic [63:0] valC_i,
  input  logic [63:0] valM_i,
  input  logic [63:0] valP_i,
  input  logic        instr_valid_i,
  input  logic        imem_error_i,
  input  logic        dmem_error_i,
  output logic [63:0] PC_o,
  output logic [2:0]  stat_o,
  output logic        running_o
`ifdef PC_UPDATE_PERF_EN
  , output logic [CNT_W-1:0] cycle_cnt_o
  , output logic [CNT_W-1:0] retired_cnt_o
`endif
);

  typedef enum logic [2:0] {
    ST_AOK = 3'd1,
    ST_HLT = 3'd2,
    ST_ADR = 3'd3,
    ST_INS = 3'd4
  } stat_e;

  localparam logic [3:0] IC_HALT = 4'd0;
  localparam logic [3:0] IC_JXX  = 4'd7;
  localparam logic [3:0] IC_CALL = 4'd8;
  localparam logic [3:0] IC_RET  = 4'd9;

  stat_e       stat_q, stat_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] next_pc_s;
  logic        commit_s;
  logic        halt_s;

  // Next-PC candidate for a committing instruction.
  always_comb begin
    next_pc_s = valP_i;
    case (icode_i)
      IC_CALL: next_pc_s = valC_i;
      IC_JXX: begin
        if (cnd_i) begin
          next_pc_s = valC_i;
        end else begin
          next_pc_s = valP_i;
        end
      end
      IC_RET:  next_pc_s = valM_i;
      default: next_pc_s = valP_i;
    endcase
  end

  // Status classification; faults and halt leave the PC on the offending instruction.
  always_comb begin
    stat_d   = stat_q;
    pc_d     = pc_q;
    commit_s = 1'b0;
    halt_s   = 1'b0;
    case (stat_q)
      ST_AOK: begin
        if (!en_i) begin
          stat_d = stat_q;
        end else if (imem_error_i) begin
          stat_d = ST_ADR;
        end else if (!instr_valid_i) begin
          stat_d = ST_INS;
        end else if (dmem_error_i) begin
          stat_d = ST_ADR;
        end else if (icode_i == IC_HALT) begin
          stat_d = ST_HLT;
          halt_s = 1'b1;
        end else begin
          commit_s = 1'b1;
          pc_d     = next_pc_s;
        end
      end
      default: stat_d = stat_q;
    endcase
  end

  // PC and status registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q   <= RESET_PC;
      stat_q <= ST_AOK;
    end else begin
      pc_q   <= pc_d;
      stat_q <= stat_d;
    end
  end

  assign PC_o      = pc_q;
  assign stat_o    = stat_q;
  assign running_o = (stat_q == ST_AOK);

`ifdef PC_UPDATE_PERF_EN
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;

  // HALT counts as retired; the faulting cycle counts only as an AOK cycle.
  always_comb begin
    cycle_cnt_d   = cycle_cnt_q;
    retired_cnt_d = retired_cnt_q;
    if ((stat_q == ST_AOK) && en_i) begin
      cycle_cnt_d = cycle_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cycle_cnt_d = cycle_cnt_q;
    end
    if (commit_s || halt_s) begin
      retired_cnt_d = retired_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retired_cnt_d = retired_cnt_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_cnt_q   <= {CNT_W{1'b0}};
      retired_cnt_q <= {CNT_W{1'b0}};
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign cycle_cnt_o   = cycle_cnt_q;
  assign retired_cnt_o = retired_cnt_q;
`endif

endmodule

// File: doc/pc_update.md
# pc_update

Program-counter register and processor status tracker for the single-cycle Y86-64 core; it sits directly upstream of `fetch` and drives its `PC_i`. Each enabled clock it selects the next PC from the current instruction's `icode`, branch condition, `valC`, `valM` and `valP`. It also maintains the architectural status (AOK/HLT/ADR/INS) and freezes the machine on halt or fault.

## Interface
- `RESET_PC`, 64'h0, PC value loaded on reset.
- `CNT_W`, 32, width of the performance counters (only when `PC_UPDATE_PERF_EN` is defined).
- `clk_i`  in  1  core clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `en_i`  in  1  advance enable; 1 = commit current instruction this edge.
- `icode_i`  in  4  current instruction code from fetch.
- `cnd_i`  in  1  branch/cmov condition from execute.
- `valC_i`  in  64  constant from fetch.
- `valM_i`  in  64  memory read value (return address for RET).
- `valP_i`  in  64  fall-through address from fetch.
- `instr_valid_i`  in  1  fetch decode validity.
- `imem_error_i`  in  1  instruction-memory address error.
- `dmem_error_i`  in  1  data-memory address error.
- `PC_o`  out  64  registered current PC, feeds fetch `PC_i`.
- `stat_o`  out  3  status: 1 AOK, 2 HLT, 3 ADR, 4 INS.
- `running_o`  out  1  1 while status is AOK.
- `cycle_cnt_o`  out  CNT_W  enabled cycles spent in AOK (perf build only).
- `retired_cnt_o`  out  CNT_W  instructions committed (perf build only).

## Operation
- State machine on `stat_o`: AOK (1), HLT (2), ADR (3), INS (4). HLT/ADR/INS are terminal; leave only via `rst_i`.
- In AOK with `en_i`=1, classify with priority: `imem_error_i` -> ADR; else `!instr_valid_i` -> INS; else `dmem_error_i` -> ADR; else `icode_i`==0 (HALT) -> HLT; else remain AOK and commit.
- Next-PC select on commit: `icode_i`==8 (CALL) -> `valC_i`; `icode_i`==7 (JXX) and `cnd_i` -> `valC_i`; `icode_i`==9 (RET) -> `valM_i`; otherwise `valP_i`.
- On any transition out of AOK, PC_o holds the address of the halting/faulting instruction (not updated).
- `en_i`=0: PC, status and counters hold.
- Terminal state: PC_o, stat_o and counters frozen regardless of `en_i` and inputs.
- Address arithmetic is not performed here; all candidates are 64-bit and passed through unmodified (no wrap handling, wrap is fetch's `valP` concern).
- `running_o` = (stat_o == AOK), combinational from the register.

## Timing
- Reset values: PC_o = RESET_PC, stat_o = 1 (AOK), running_o = 1, cycle_cnt_o = 0, retired_cnt_o = 0.
- `rst_i` has priority over `en_i` and all data inputs on the same edge; reset mid-run or from terminal state returns to reset values next edge.
- Single-cycle latency: inputs sampled at edge N produce PC_o/stat_o at edge N; combinational path PC_o -> fetch -> execute -> next-PC mux must close within one period.
- Fault/halt and commit are mutually exclusive on one edge; stat_o changes and PC_o does not.
- No combinational path from inputs to outputs.

## Configuration
- `PC_UPDATE_PERF_EN` defined: `cycle_cnt_o` increments on every edge with `en_i`=1 and stat AOK (including the halting/faulting cycle); `retired_cnt_o` increments on commit and on HALT (HALT counts as retired, ADR/INS do not). Both wrap modulo 2^CNT_W, freeze in terminal states, clear on reset.
- Not defined: both counter ports and registers are absent; all other behaviour identical.

## Test plan
- Reset with RESET_PC=0, then `icode_i`=3, `valP_i`=10, en=1 -> PC_o=10, stat_o=1; next `valP_i`=20 -> PC_o=20.
- JXX at PC 30: `icode_i`=7, `valC_i`=39, `cnd_i`=1 -> PC_o=39; repeat with `cnd_i`=0, `valP_i`=39+11=50 path: `valP_i`=50 -> PC_o=50.
- CALL `valC_i`=0x100 -> PC_o=0x100; then RET `valM_i`=0x2A -> PC_o=0x2A; `en_i`=0 for 3 cycles -> PC_o stays 0x2A.
- HALT at PC 124 (`icode_i`=0) -> stat_o=2, PC_o=124, running_o=0; further edges with en=1 and new valP -> no change; `rst_i`=1 -> PC_o=0, stat_o=1.
- Simultaneous `imem_error_i`=1 and `instr_valid_i`=0 -> stat_o=3 (ADR); separately `instr_valid_i`=0 alone -> stat_o=4; `dmem_error_i`=1 with HALT icode -> stat_o=3.
- Perf build: 5 commits, 2 en=0 cycles, then HALT -> cycle_cnt_o=6, retired_cnt_o=6; CNT_W=4 with 17 commits -> retired_cnt_o=1.
